// File: rtl/receptor_mdio_param.sv
// receptor_mdio_param: parametrised Clause-22 MDIO receiver (PHY side).
// Finds a preamble, decodes ST/OP/PHYAD/REGAD/TA/DATA and filters on PHY_ADDR.
// A write frame ends in a write strobe. A read frame requests RD_DATA and shifts it back out.
// Optional feature macro: MDIO_BROADCAST_EN. When it is defined, PHYAD 0 is accepted for write frames.
module receptor_mdio_param #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32,
  parameter int         REG_AW       = 5,
  parameter int         DATA_W       = 16
) (
  input  logic              MDC,
  input  logic              reset_n,
  input  logic              MDIO_OUT,
  input  logic              MDIO_OE,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              MDIO_IN,
  output logic              MDIO_IN_OE,
  output logic [REG_AW-1:0] ADDR,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_STB,
  output logic              RD_STB,
  output logic              MDIO_DONE,
  output logic              FRAME_ERR
);

  // The shared field shift register must hold the widest field: DATA, REGAD or PHYAD.
  localparam int SH_W_A   = (DATA_W > REG_AW) ? DATA_W : REG_AW;
  localparam int SH_W     = (SH_W_A > 5) ? SH_W_A : 5;
  localparam int SKIP_LEN = REG_AW + 2 + DATA_W;
  localparam int CNT_W    = $clog2(SKIP_LEN + 1);
  localparam int PRE_W    = $clog2(PREAMBLE_MIN + 1);

  localparam logic [PRE_W-1:0] PRE_FULL  = PRE_W'(PREAMBLE_MIN);
  localparam logic [CNT_W-1:0] PHY_LAST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] REG_LAST  = CNT_W'(REG_AW - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_ST    = 4'd1, S_OP    = 4'd2,
    S_PHYAD = 4'd3, S_REGAD = 4'd4, S_TA    = 4'd5,
    S_WDATA = 4'd6, S_RDATA = 4'd7, S_SKIP  = 4'd8
  } state_t;

  state_t            state_r, state_s;
  logic [PRE_W-1:0]  pre_cnt_r, pre_cnt_s;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_s, cnt_inc_s;
  logic [SH_W-2:0]   sh_r, sh_s;
  logic [SH_W-1:0]   nxt_s;
  logic              is_read_r, is_read_s;
  logic [DATA_W-1:0] rd_shift_r, rd_shift_s;
  logic [REG_AW-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wr_data_r, wr_data_s;
  logic              mdio_in_r, mdio_in_s, mdio_in_oe_r, mdio_in_oe_s;
  logic              wr_stb_r, wr_stb_s, rd_stb_r, rd_stb_s;
  logic              done_r, done_s, err_r, err_s;
  logic              phy_match_s, bcast_s;

  // The sampled line bit is appended to the history. Each field is read from the low bits.
  assign nxt_s       = {sh_r, MDIO_OUT};
  assign cnt_inc_s   = bit_cnt_r + CNT_W'(1);
  assign phy_match_s = (nxt_s[4:0] == PHY_ADDR);

`ifdef MDIO_BROADCAST_EN
  assign bcast_s = (nxt_s[4:0] == 5'd0) && !is_read_r;
`else
  assign bcast_s = 1'b0;
`endif

  // Next-state, field decode and output strobes for the frame FSM.
  always_comb begin
    state_s      = state_r;
    pre_cnt_s    = pre_cnt_r;
    bit_cnt_s    = bit_cnt_r;
    sh_s         = nxt_s[SH_W-2:0];
    is_read_s    = is_read_r;
    rd_shift_s   = rd_shift_r;
    addr_s       = addr_r;
    wr_data_s    = wr_data_r;
    mdio_in_s    = 1'b0;
    mdio_in_oe_s = 1'b0;
    wr_stb_s     = 1'b0;
    rd_stb_s     = 1'b0;
    done_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!MDIO_OE) begin
          pre_cnt_s = pre_cnt_r;
        end else if (MDIO_OUT) begin
          if (pre_cnt_r != PRE_FULL) pre_cnt_s = pre_cnt_r + PRE_W'(1);
          else                       pre_cnt_s = pre_cnt_r;
        end else if (pre_cnt_r == PRE_FULL) begin
          state_s   = S_ST;
          pre_cnt_s = '0;
        end else begin
          pre_cnt_s = '0;
        end
      end
      S_ST: begin
        if (!MDIO_OE || !MDIO_OUT) begin
          err_s = 1'b1; state_s = S_IDLE;
        end else begin
          state_s = S_OP; bit_cnt_s = '0;
        end
      end
      S_OP: begin
        if (!MDIO_OE) begin
          err_s = 1'b1; state_s = S_IDLE;
        end else if (bit_cnt_r == '0) begin
          bit_cnt_s = cnt_inc_s;
        end else begin
          bit_cnt_s = '0;
          case (nxt_s[1:0])
            2'b01:   begin is_read_s = 1'b0; state_s = S_PHYAD; end
            2'b10:   begin is_read_s = 1'b1; state_s = S_PHYAD; end
            default: begin err_s = 1'b1;     state_s = S_IDLE;  end
          endcase
        end
      end
      S_PHYAD: begin
        if (!MDIO_OE) begin
          err_s = 1'b1; state_s = S_IDLE;
        end else if (bit_cnt_r != PHY_LAST) begin
          bit_cnt_s = cnt_inc_s;
        end else begin
          bit_cnt_s = '0;
          if (phy_match_s || bcast_s) state_s = S_REGAD;
          else                        state_s = S_SKIP;
        end
      end
      S_REGAD: begin
        if (!MDIO_OE) begin
          err_s = 1'b1; state_s = S_IDLE;
        end else if (bit_cnt_r != REG_LAST) begin
          bit_cnt_s = cnt_inc_s;
        end else begin
          bit_cnt_s = '0;
          addr_s    = nxt_s[REG_AW-1:0];
          rd_stb_s  = is_read_r;
          state_s   = S_TA;
        end
      end
      S_TA: begin
        if (is_read_r) begin
          // The controller has released the line. The bank answers the cycle after RD_STB.
          if (bit_cnt_r == '0) begin
            rd_shift_s = RD_DATA;
            bit_cnt_s  = CNT_W'(1);
          end else begin
            bit_cnt_s    = '0;
            mdio_in_oe_s = 1'b1;
            mdio_in_s    = 1'b0;
            state_s      = S_RDATA;
          end
        end else if (!MDIO_OE) begin
          err_s = 1'b1; state_s = S_IDLE;
        end else if (bit_cnt_r == '0) begin
          if (MDIO_OUT) begin
            bit_cnt_s = CNT_W'(1);
          end else begin
            err_s = 1'b1; state_s = S_IDLE;
          end
        end else begin
          if (!MDIO_OUT) begin
            bit_cnt_s = '0; state_s = S_WDATA;
          end else begin
            err_s = 1'b1; state_s = S_IDLE;
          end
        end
      end
      S_WDATA: begin
        if (!MDIO_OE) begin
          err_s = 1'b1; state_s = S_IDLE;
        end else if (bit_cnt_r != DATA_LAST) begin
          bit_cnt_s = cnt_inc_s;
        end else begin
          bit_cnt_s = '0;
          wr_data_s = nxt_s[DATA_W-1:0];
          wr_stb_s  = 1'b1;
          done_s    = 1'b1;
          state_s   = S_IDLE;
        end
      end
      S_RDATA: begin
        if (bit_cnt_r != DATA_END) begin
          mdio_in_oe_s = 1'b1;
          mdio_in_s    = rd_shift_r[DATA_W-1];
          rd_shift_s   = {rd_shift_r[DATA_W-2:0], 1'b0};
          bit_cnt_s    = cnt_inc_s;
        end else begin
          bit_cnt_s = '0;
          done_s    = 1'b1;
          state_s   = S_IDLE;
        end
      end
      S_SKIP: begin
        if (bit_cnt_r != SKIP_LAST) begin
          bit_cnt_s = cnt_inc_s;
        end else begin
          bit_cnt_s = '0;
          state_s   = S_IDLE;
        end
      end
      default: begin
        state_s   = S_IDLE;
        bit_cnt_s = '0;
        pre_cnt_s = '0;
      end
    endcase
  end

  // State, counters, field registers and registered outputs.
  always_ff @(posedge MDC or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      pre_cnt_r    <= '0;
      bit_cnt_r    <= '0;
      sh_r         <= '0;
      is_read_r    <= 1'b0;
      rd_shift_r   <= '0;
      addr_r       <= '0;
      wr_data_r    <= '0;
      mdio_in_r    <= 1'b0;
      mdio_in_oe_r <= 1'b0;
      wr_stb_r     <= 1'b0;
      rd_stb_r     <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      pre_cnt_r    <= pre_cnt_s;
      bit_cnt_r    <= bit_cnt_s;
      sh_r         <= sh_s;
      is_read_r    <= is_read_s;
      rd_shift_r   <= rd_shift_s;
      addr_r       <= addr_s;
      wr_data_r    <= wr_data_s;
      mdio_in_r    <= mdio_in_s;
      mdio_in_oe_r <= mdio_in_oe_s;
      wr_stb_r     <= wr_stb_s;
      rd_stb_r     <= rd_stb_s;
      done_r       <= done_s;
      err_r        <= err_s;
    end
  end

  assign MDIO_IN    = mdio_in_r;
  assign MDIO_IN_OE = mdio_in_oe_r;
  assign ADDR       = addr_r;
  assign WR_DATA    = wr_data_r;
  assign WR_STB     = wr_stb_r;
  assign RD_STB     = rd_stb_r;
  assign MDIO_DONE  = done_r;
  assign FRAME_ERR  = err_r;

endmodule

// File: tb/tb_receptor_mdio_param.sv
// Scoreboard bench for receptor_mdio_param (PHY_ADDR=1, 32-bit preamble, 5/16-bit fields).
// Frame tasks push the expected output events. A negedge monitor pops one event on
// every cycle in which any strobe or the line drive is active.
module tb_receptor_mdio_param;

  logic        MDC = 1'b0;
  logic        reset_n;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        MDIO_IN, MDIO_IN_OE, WR_STB, RD_STB, MDIO_DONE, FRAME_ERR;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;

  // Event record: {wr_stb, rd_stb, done, err, oe, mdio_in, addr[4:0], wr_data[15:0]}
  typedef logic [26:0] rec_t;

  rec_t        exp_q[$];
  rec_t        got_rec, exp_rec;
  int          tests = 0;
  int          fails = 0;
  logic [4:0]  exp_addr = 5'd0;
  logic [15:0] exp_wd   = 16'd0;

  receptor_mdio_param dut (
    .MDC(MDC), .reset_n(reset_n), .MDIO_OUT(MDIO_OUT), .MDIO_OE(MDIO_OE),
    .RD_DATA(RD_DATA), .MDIO_IN(MDIO_IN), .MDIO_IN_OE(MDIO_IN_OE), .ADDR(ADDR),
    .WR_DATA(WR_DATA), .WR_STB(WR_STB), .RD_STB(RD_STB), .MDIO_DONE(MDIO_DONE),
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 MDC = ~MDC;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic rec_t mk(input logic wr, input logic rd, input logic dn, input logic er,
                              input logic oe, input logic din, input logic [4:0] a,
                              input logic [15:0] d);
    return {wr, rd, dn, er, oe, din, a, d};
  endfunction

  // Monitor: every active output cycle must match the head of the expectation queue.
  always @(negedge MDC) begin
    if (reset_n && (WR_STB || RD_STB || MDIO_DONE || FRAME_ERR || MDIO_IN_OE)) begin
      got_rec = {WR_STB, RD_STB, MDIO_DONE, FRAME_ERR, MDIO_IN_OE, MDIO_IN, ADDR, WR_DATA};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got wr/rd/done/err/oe/in=%b addr=%h wdata=%h, required no event",
                 got_rec[26:21], got_rec[20:16], got_rec[15:0]);
      end else begin
        exp_rec = exp_q.pop_front();
        if (got_rec !== exp_rec)
          begin
            fails++;
            $display("FAIL scoreboard: got wr/rd/done/err/oe/in=%b addr=%h wdata=%h, required %b addr=%h wdata=%h",
                     got_rec[26:21], got_rec[20:16], got_rec[15:0],
                     exp_rec[26:21], exp_rec[20:16], exp_rec[15:0]);
          end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send_bits(input logic oe, input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      MDIO_OE  = oe;
      MDIO_OUT = val[i];
      @(posedge MDC);
      #1;
    end
  endtask

  task automatic send_header(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra);
    send_bits(1'b1, 32'hFFFF_FFFF, 32);
    send_bits(1'b1, 32'h0000_0001, 2);
    send_bits(1'b1, {30'd0, op}, 2);
    send_bits(1'b1, {27'd0, phy}, 5);
    send_bits(1'b1, {27'd0, ra}, 5);
  endtask

  task automatic wr_frame(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] d);
    send_header(2'b01, phy, ra);
    send_bits(1'b1, 32'h0000_0002, 2);
    send_bits(1'b1, {16'd0, d}, 16);
  endtask

  // Read frame: after REGAD the controller releases the line for TA, DATA and the closing edge.
  task automatic rd_frame(input logic [4:0] phy, input logic [4:0] ra);
    send_header(2'b10, phy, ra);
    send_bits(1'b0, 32'd0, 19);
  endtask

  task automatic exp_write(input logic [4:0] ra, input logic [15:0] d);
    exp_addr = ra;
    exp_wd   = d;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr, exp_wd));
  endtask

  task automatic exp_read(input logic [4:0] ra, input logic [15:0] d, input int nbits, input logic fin);
    exp_addr = ra;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_addr, exp_wd));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, exp_addr, exp_wd));
    for (int i = 15; i > 15 - nbits; i--)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d[i], exp_addr, exp_wd));
    if (fin) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, exp_addr, exp_wd));
  endtask

  task automatic exp_err();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, exp_addr, exp_wd));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mdio_in_oe"}, {31'd0, MDIO_IN_OE}, 32'd0);
    check({tag, "_mdio_in"},    {31'd0, MDIO_IN},    32'd0);
    check({tag, "_wr_stb"},     {31'd0, WR_STB},     32'd0);
    check({tag, "_rd_stb"},     {31'd0, RD_STB},     32'd0);
    check({tag, "_done"},       {31'd0, MDIO_DONE},  32'd0);
    check({tag, "_frame_err"},  {31'd0, FRAME_ERR},  32'd0);
    check({tag, "_addr"},       {27'd0, ADDR},       32'd0);
    check({tag, "_wr_data"},    {16'd0, WR_DATA},    32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b1;
    RD_DATA  = 16'h0000;
    repeat (3) @(posedge MDC);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(posedge MDC);
    #1;

    // 1: write to own PHY, REGAD 3, data A5C3
    exp_write(5'h03, 16'hA5C3);
    wr_frame(5'd1, 5'h03, 16'hA5C3);

    // 2: back-to-back read of REGAD 7, bank returns 1234
    RD_DATA = 16'h1234;
    exp_read(5'h07, 16'h1234, 16, 1'b1);
    rd_frame(5'd1, 5'h07);

    // 3: write to foreign PHY 4 is skipped; the next valid frame is still accepted
    wr_frame(5'd4, 5'h15, 16'h3C3C);
    check("addr_after_skip", {27'd0, ADDR}, 32'h0000_0007);
    exp_write(5'h1E, 16'h0F0F);
    wr_frame(5'd1, 5'h1E, 16'h0F0F);

    // 4a: a 20-bit preamble is too short, so the whole frame is ignored
    send_bits(1'b1, 32'h000F_FFFF, 20);
    send_bits(1'b1, 32'h0000_0001, 2);
    send_bits(1'b1, 32'h0000_0001, 2);
    send_bits(1'b1, 32'h0000_0001, 5);
    send_bits(1'b1, 32'h0000_0003, 5);
    send_bits(1'b1, 32'h0000_0002, 2);
    send_bits(1'b1, 32'h0000_1234, 16);
    // 4b: OP=11 after a valid preamble gives a single FRAME_ERR
    exp_err();
    send_bits(1'b1, 32'hFFFF_FFFF, 32);
    send_bits(1'b1, 32'h0000_0001, 2);
    send_bits(1'b1, 32'h0000_0003, 2);

    // 5a: MDIO_OE drops in the middle of WDATA (ADDR already updated to 5)
    send_header(2'b01, 5'd1, 5'h05);
    send_bits(1'b1, 32'h0000_0002, 2);
    send_bits(1'b1, 32'h0000_00FF, 8);
    exp_addr = 5'h05;
    exp_err();
    send_bits(1'b0, 32'd0, 1);

    // 6: broadcast PHYAD 0; a read is never answered, a write only with the feature
`ifdef MDIO_BROADCAST_EN
    exp_write(5'h09, 16'hBEEF);
`endif
    wr_frame(5'd0, 5'h09, 16'hBEEF);
    rd_frame(5'd0, 5'h04);

    // 5b: reset in the middle of RDATA releases the line at once
    RD_DATA = 16'hFFFF;
    exp_read(5'h02, 16'hFFFF, 3, 1'b0);
    send_header(2'b10, 5'd1, 5'h02);
    send_bits(1'b0, 32'd0, 6);
    check("oe_mid_rdata", {31'd0, MDIO_IN_OE}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    check("queue_drained_at_reset", exp_q.size(), 32'd0);
    exp_addr = 5'd0;
    exp_wd   = 16'd0;
    repeat (2) @(posedge MDC);
    #1;
    reset_n = 1'b1;

    // Recovery after reset
    exp_write(5'h11, 16'h5AA5);
    wr_frame(5'd1, 5'h11, 16'h5AA5);

    repeat (5) @(posedge MDC);
    #1;
    check("queue_drained_at_end", exp_q.size(), 32'd0);
    check("final_addr", {27'd0, ADDR}, {27'd0, exp_addr});
    check("final_wr_data", {16'd0, WR_DATA}, {16'd0, exp_wd});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
